// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared FSM encodings and byte-lane mask constants for the dmem port
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Lane masks; also used by the hart when it builds store/load requests.
  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  function automatic logic [31:0] lane_bits(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word storage with byte-masked synchronous write and combinational read
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = ""
) (
  input  logic                           i_clk,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  input  logic [3:0]                     i_wmask,
  output logic [31:0]                    o_rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < 4; k++) begin
        if (i_wmask[k]) begin
          mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end
    end
  end

  assign o_rdata = mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dmem target with valid/ready request/response handshakes and programmable latency
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter              INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic          accept, commit;

  logic [31:0]   offset;
  logic          req_err;

  logic [AW-1:0] idx_q;
  logic          ren_q, wen_q, err_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;

  logic [AW-1:0] cur_idx;
  logic          cur_ren, cur_wen, cur_err;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_mask;
  logic [31:0]   rd_word;

  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;
  logic          unused_addr_bits;

  // Anything beyond the low AW+2 offset bits being set means the word index is out of range.
  assign offset  = i_req_addr - BASE_ADDR;
  assign req_err = (i_req_ren == i_req_wen) | (i_req_addr < BASE_ADDR) | (|(offset >> (AW + 2)));
  assign unused_addr_bits = ^offset[1:0];

  assign o_req_ready = (state == ST_IDLE) & ~i_rst;
  assign accept      = i_req_valid & o_req_ready;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A zero-latency commit happens on the acceptance edge, so it must see the live request.
  assign cur_idx   = (state == ST_IDLE) ? offset[AW+1:2] : idx_q;
  assign cur_ren   = (state == ST_IDLE) ? i_req_ren      : ren_q;
  assign cur_wen   = (state == ST_IDLE) ? i_req_wen      : wen_q;
  assign cur_err   = (state == ST_IDLE) ? req_err        : err_q;
  assign cur_wdata = (state == ST_IDLE) ? i_req_wdata    : wdata_q;
  assign cur_mask  = (state == ST_IDLE) ? i_req_mask     : mask_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (commit & cur_wen & ~cur_err & ~i_rst),
    .i_addr  (cur_idx),
    .i_wdata (cur_wdata),
    .i_wmask (cur_mask),
    .o_rdata (rd_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (commit) begin
        rsp_err_q   <= cur_err;
        rsp_rdata_q <= (cur_ren & ~cur_err) ? (rd_word & lane_bits(cur_mask)) : 32'd0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      idx_q   <= offset[AW+1:2];
      ren_q   <= i_req_ren;
      wen_q   <= i_req_wen;
      err_q   <= req_err;
      wdata_q <= i_req_wdata;
      mask_q  <= i_req_mask;
    end
  end

  assign o_rsp_valid = (state == ST_RESP);
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder at latency 2 and latency 0
module tb_dmem_responder;

  localparam int TB_DEPTH = 4096;
  localparam int TB_BASE  = 0;

  logic              clk;
  logic [1:0]        rst;
  logic [1:0]        req_valid, req_ready, ren, wen;
  logic [1:0][31:0]  addr, wdata, rsp_rdata;
  logic [1:0][3:0]   mask;
  logic [1:0]        rsp_valid, rsp_ready, rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  bit [31:0] mdl [2][TB_DEPTH];

  dmem_responder #(.DEPTH_WORDS(TB_DEPTH), .LATENCY(2), .BASE_ADDR(32'h0), .INIT_FILE("")) u_dut_lat2 (
    .i_clk(clk), .i_rst(rst[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_addr(addr[0]), .i_req_ren(ren[0]), .i_req_wen(wen[0]), .i_req_wdata(wdata[0]),
    .i_req_mask(mask[0]), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(TB_DEPTH), .LATENCY(0), .BASE_ADDR(32'h0), .INIT_FILE("")) u_dut_lat0 (
    .i_clk(clk), .i_rst(rst[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_addr(addr[1]), .i_req_ren(ren[1]), .i_req_wen(wen[1]), .i_req_wdata(wdata[1]),
    .i_req_mask(mask[1]), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_eval(input int d, input logic [31:0] a, input logic r, input logic w,
                                     input logic [3:0] m, output logic err, output logic [31:0] rd);
    longint word;
    logic [31:0] lanes;
    word = (longint'(a) - TB_BASE) / 4;
    err  = (r == w) || (longint'(a) < TB_BASE) || (word >= TB_DEPTH);
    rd   = 32'd0;
    if (!err && r) begin
      lanes = 32'd0;
      for (int k = 0; k < 4; k++) if (m[k]) lanes = lanes | (32'hFF << (8 * k));
      rd = mdl[d][int'(word)] & lanes;
    end
  endfunction

  function automatic void model_commit(input int d, input logic [31:0] a, input logic w,
                                       input logic [31:0] wd, input logic [3:0] m, input logic err);
    int word;
    word = int'((longint'(a) - TB_BASE) / 4);
    if (!err && w)
      for (int k = 0; k < 4; k++) if (m[k]) mdl[d][word][8*k +: 8] = wd[8*k +: 8];
  endfunction

  task automatic do_req(input int d, input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] wd, input logic [3:0] m, input int stall,
                        output logic [31:0] got, output logic got_err);
    logic        e_err;
    logic [31:0] e_rd;
    int          k;
    model_eval(d, a, r, w, m, e_err, e_rd);
    k = 0;
    while (!req_ready[d] && k < 50) begin @(negedge clk); k++; end
    chk("req_ready_idle", req_ready[d], 1);
    req_valid[d] = 1'b1; addr[d] = a; ren[d] = r; wen[d] = w; wdata[d] = wd; mask[d] = m;
    @(negedge clk);
    req_valid[d] = 1'b0; addr[d] = $urandom; ren[d] = 1'($urandom); wen[d] = 1'($urandom);
    wdata[d] = $urandom; mask[d] = 4'($urandom);
    k = 1;
    while (!rsp_valid[d] && k < 40) begin @(negedge clk); k++; end
    chk("rsp_latency", k, (d == 0) ? 3 : 1);
    chk("rsp_err", rsp_err[d], e_err);
    chk("rsp_rdata", rsp_rdata[d], e_rd);
    got = rsp_rdata[d];
    got_err = rsp_err[d];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid[d], 1);
      chk("hold_rdata", rsp_rdata[d], e_rd);
      chk("hold_req_ready", req_ready[d], 0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("rsp_done", rsp_valid[d], 0);
    chk("req_ready_after", req_ready[d], 1);
    model_commit(d, a, w, wd, m, e_err);
  endtask

  task automatic random_ops(input int d, input int n);
    logic [31:0] a, got;
    logic        r, w, ge;
    int          kind;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      r = 1'($urandom);
      w = ~r;
      a = 32'h1000 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
      if (kind >= 6 && kind < 8) w = r;
      if (kind >= 8) a = 32'h4000 + $urandom_range(0, 32'h7FFF_0000);
      do_req(d, a, r, w, $urandom, 4'($urandom), $urandom_range(0, 2), got, ge);
    end
  endtask

  logic [31:0] got, prior;
  logic        gerr;

  initial begin
    rst = 2'b11; req_valid = '0; rsp_ready = '0; ren = '0; wen = '0;
    addr = '0; wdata = '0; mask = '0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset_l2", req_ready[0], 0);
    chk("ready_in_reset_l0", req_ready[1], 0);
    rst = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_rsp_valid", rsp_valid[d], 0);
      chk("reset_rsp_rdata", rsp_rdata[d], 0);
      chk("reset_rsp_err", rsp_err[d], 0);
      chk("reset_req_ready", req_ready[d], 1);
    end

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) do_req(d, 32'h1000 + 4 * i, 1'b0, 1'b1, $urandom, 4'hF, 0, got, gerr);
      do_req(d, 32'h2000, 1'b0, 1'b1, $urandom, 4'hF, 0, got, gerr);
    end

    do_req(0, 32'h1000, 1'b0, 1'b1, 32'hDEADBEEF, 4'b1111, 0, got, gerr);
    chk("wr_rdata_zero", got, 32'h0);
    chk("wr_err_zero", gerr, 0);
    do_req(0, 32'h1000, 1'b1, 1'b0, 32'h0, 4'b1111, 0, got, gerr);
    chk("rd_word", got, 32'hDEADBEEF);
    do_req(0, 32'h1003, 1'b0, 1'b1, 32'hAA000000, 4'b1000, 0, got, gerr);
    do_req(0, 32'h1000, 1'b1, 1'b0, 32'h0, 4'b1111, 0, got, gerr);
    chk("rd_after_byte", got, 32'hAAADBEEF);
    do_req(0, 32'h1002, 1'b1, 1'b0, 32'h0, 4'b1100, 0, got, gerr);
    chk("rd_halfword", got, 32'hAAAD0000);
    do_req(0, 32'h1000, 1'b1, 1'b1, 32'h11111111, 4'b1111, 0, got, gerr);
    chk("ill_rw_err", gerr, 1);
    chk("ill_rw_rdata", got, 32'h0);
    do_req(0, 32'h1000 + 4 * TB_DEPTH, 1'b0, 1'b1, 32'h22222222, 4'b1111, 0, got, gerr);
    chk("ill_range_err", gerr, 1);
    do_req(0, 32'h1000, 1'b0, 1'b0, 32'h33333333, 4'b1111, 0, got, gerr);
    chk("ill_none_err", gerr, 1);
    do_req(0, 32'h1000, 1'b1, 1'b0, 32'h0, 4'b0000, 0, got, gerr);
    chk("mask0_rdata", got, 32'h0);
    chk("mask0_err", gerr, 0);
    do_req(0, 32'h1000, 1'b1, 1'b0, 32'h0, 4'b1111, 5, got, gerr);
    chk("rd_after_illegal", got, 32'hAAADBEEF);

    // Reset lands on the commit edge of a write: the write must not happen.
    prior = mdl[0][32'h2000 / 4];
    req_valid[0] = 1'b1; addr[0] = 32'h2000; ren[0] = 1'b0; wen[0] = 1'b1;
    wdata[0] = 32'h12345678; mask[0] = 4'b1111;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("no_rsp_after_wait_reset", rsp_valid[0], 0);
      @(negedge clk);
    end
    do_req(0, 32'h2000, 1'b1, 1'b0, 32'h0, 4'b1111, 0, got, gerr);
    chk("wait_reset_prior", got, prior);

    do_req(1, 32'h1000, 1'b0, 1'b1, 32'hCAFEF00D, 4'b1111, 0, got, gerr);
    do_req(1, 32'h1000, 1'b1, 1'b0, 32'h0, 4'b1111, 2, got, gerr);
    chk("l0_rd_word", got, 32'hCAFEF00D);

    // Reset in RESP drops the response, but the write already committed.
    req_valid[1] = 1'b1; addr[1] = 32'h2000; ren[1] = 1'b0; wen[1] = 1'b1;
    wdata[1] = 32'h0BADF00D; mask[1] = 4'b1111;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("l0_resp_next_cycle", rsp_valid[1], 1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    chk("l0_resp_dropped", rsp_valid[1], 0);
    model_commit(1, 32'h2000, 1'b1, 32'h0BADF00D, 4'b1111, 1'b0);
    do_req(1, 32'h2000, 1'b1, 1'b0, 32'h0, 4'b1111, 0, got, gerr);
    chk("l0_resp_reset_write", got, 32'h0BADF00D);

    random_ops(0, 40);
    random_ops(1, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
